// File: rtl/shift_right_sequential.sv
// Multi-cycle logarithmic right shifter (logical or arithmetic), one binary-weighted stage
// per clock, with valid/ready handshakes on both the operand and the result side.
module shift_right_sequential #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  input  logic [N-1:0] shamt,
  input  logic         arith,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         busy
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   k_q, k_d;
  logic [N-1:0] work_q, work_d;
  logic [4:0]   amt_q, amt_d;
  logic         arith_q, arith_d;

  logic         stage_en;
  logic [4:0]   stage_amt;
  logic [N-1:0] stage_res;

  // Only shamt[4:0] selects the shift; the upper bits are deliberately ignored.
  logic unused_shamt;
  assign unused_shamt = ^shamt[N-1:5];

  // Stage k shifts by 2^k when bit k of the captured amount is set.
  always_comb begin
    stage_en  = 1'b0;
    stage_amt = 5'd0;
    unique case (k_q)
      3'd0: begin stage_en = amt_q[0]; stage_amt = 5'd1;  end
      3'd1: begin stage_en = amt_q[1]; stage_amt = 5'd2;  end
      3'd2: begin stage_en = amt_q[2]; stage_amt = 5'd4;  end
      3'd3: begin stage_en = amt_q[3]; stage_amt = 5'd8;  end
      3'd4: begin stage_en = amt_q[4]; stage_amt = 5'd16; end
      default: begin stage_en = 1'b0; stage_amt = 5'd0; end
    endcase
  end

  // The sign bit never changes across stages, so sign-fill from the working register is exact.
  always_comb begin
    if (arith_q) begin
      stage_res = $unsigned($signed(work_q) >>> stage_amt);
    end else begin
      stage_res = work_q >> stage_amt;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    work_d  = work_q;
    amt_d   = amt_q;
    arith_d = arith_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = in;
          amt_d   = shamt[4:0];
          arith_d = arith;
          k_d     = 3'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (stage_en) begin
          work_d = stage_res;
        end
        k_d = k_q + 3'd1;
        if (k_q == 3'd4) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= 3'd0;
      work_q  <= '0;
      amt_q   <= 5'd0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      arith_q <= arith_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out       = work_q;

endmodule

// File: tb/tb_shift_right_sequential.sv
// Self-checking bench for shift_right_sequential: directed cases with literal expectations plus
// randomized traffic checked every cycle against a latency/result reference model.
module tb_shift_right_sequential;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic [31:0] shamt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  shift_right_sequential #(.N(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (din),
    .shamt    (shamt),
    .arith    (arith),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (dout),
    .busy     (busy)
  );

  // Result by plain arithmetic: amount modulo 32; sign fill via the complement identity.
  function automatic logic [31:0] ref_shift(logic [31:0] v, logic [31:0] s, logic a);
    int sh;
    sh = int'(s % 32);
    if (a && v[31]) return ~((~v) >> sh);
    return v >> sh;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an accepted op yields its result 5 stage edges later, held until out_ready.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_res = '0;
  int          accepts = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy  <= 1'b1;
        m_cnt   <= 0;
        m_res   <= ref_shift(din, shamt, arith);
        accepts <= accepts + 1;
      end
    end else if (m_cnt < 5) begin
      m_cnt <= m_cnt + 1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_in_ready", 32'(in_ready), 32'(!m_busy));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_out_valid", 32'(out_valid), 32'(m_busy && m_cnt == 5));
      if (m_busy && m_cnt == 5) check("cyc_out", dout, m_res);
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", 32'(in_ready), 32'd1);
  endtask

  // Present one op, scramble inputs after acceptance, measure latency, check the literal result.
  task automatic run_op(input logic [31:0] v, input logic [31:0] s, input logic a,
                        input logic [31:0] exp, input string name);
    int lat = 0;
    wait_ready();
    in_valid  = 1'b1;
    din       = v;
    shamt     = s;
    arith     = a;
    out_ready = 1'b0;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    din      = $urandom;
    shamt    = $urandom;
    arith    = ~a;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check({name, "_latency"}, 32'(lat), 32'd6);
    check({name, "_out"}, dout, exp);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    din       = '0;
    shamt     = '0;
    arith     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out", dout, 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    chk_en = 1'b1;

    run_op(32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000, "srl4");
    release_result();
    run_op(32'h8000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF, "sra31");
    release_result();
    run_op(32'h8000_0000, 32'd31, 1'b0, 32'h0000_0001, "srl31");
    release_result();
    run_op(32'h1234_5678, 32'h25, 1'b0, 32'h0091_A2B3, "srl_wrap");
    release_result();
    run_op(32'h1234_5678, 32'd0, 1'b0, 32'h1234_5678, "shamt0");
    release_result();

    // Backpressure with an intruding operand while busy.
    run_op(32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000, "sra4");
    in_valid = 1'b1;
    din      = 32'hDEAD_BEEF;
    shamt    = 32'd1;
    arith    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_out", dout, 32'hF800_0000);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    din   = 32'h0000_0010;
    shamt = 32'd4;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    check("next_accept_busy", 32'(busy), 32'd1);
    repeat (6) @(negedge clk);
    check("next_accept_out", dout, 32'h0000_0001);
    check("next_accept_valid", 32'(out_valid), 32'd1);
    release_result();

    // Reset during SHIFT stage 2.
    wait_ready();
    in_valid = 1'b1;
    din      = 32'hFFFF_0000;
    shamt    = 32'd3;
    arith    = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    check("midrst_out", dout, 32'h0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    run_op(32'h0000_FF00, 32'd8, 1'b0, 32'h0000_00FF, "post_rst");
    release_result();

    // Randomized traffic with random stalls; the per-cycle compare does the checking.
    begin
      int target;
      int cyc = 0;
      target = accepts + 500;
      while (accepts < target && cyc < 30000) begin
        @(negedge clk);
        in_valid  = ($urandom_range(0, 3) != 0);
        din       = $urandom;
        shamt     = $urandom;
        if ($urandom_range(0, 7) == 0) shamt[4:0] = ($urandom_range(0, 1) != 0) ? 5'd31 : 5'd0;
        arith     = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 2) != 0);
        cyc++;
      end
      check("random_accepts", 32'(accepts), 32'(target));
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
